// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Moore-style control FSM for a multicycle MIPS datapath (lw, sw, R-type,
//   beq, j, addi). Memory accesses in FETCH, MEMRD and MEMWR stretch until
//   mem_ready is high. The FETCH write enables, the MEMWR completion and the
//   DECODE illegal-op pulse also depend on the current inputs.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high; also forces all outputs to 0
//   Op[5:0]      in   opcode IR[31:26], used combinationally (never registered)
//   mem_ready    in   memory has completed the current access
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   ALUSrcA, RegWrite, RegDst                      out  datapath controls
//   PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0]        out  datapath selects
//   state[3:0]   out  current FSM state (debug)
//   instr_done   out  pulse on the last cycle of each instruction
//   illegal_op   out  pulse when DECODE sees an unsupported opcode
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] RWB    = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYP:      w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          OP_ADDI:      w_next = ADDIEX;
          default:      w_next = FETCH;
        endcase
      end
      MEMADR: w_next = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  w_next = mem_ready ? MEMWB : MEMRD;
      MEMWR:  w_next = mem_ready ? FETCH : MEMWR;
      EXEC:   w_next = RWB;
      ADDIEX: w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  // Output decode. Everything is held at 0 while reset is high, so a reset
  // that lands mid-instruction cannot leak a final write of any kind.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          // PC and IR only update on the cycle the fetch actually completes.
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          if (w_next == FETCH) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        RWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = reset ? FETCH : r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each step applies Op/mem_ready/reset,
// compares state and the packed control vector against hand-written values,
// then advances one clock.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  // Packing: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //           ALUSrcA,RegWrite,RegDst, PCSource, ALUOp, ALUSrcB,
  //           instr_done, illegal_op}
  logic [17:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
                instr_done, illegal_op};

  localparam logic [17:0] C_ZERO    = 18'd0;
  localparam logic [17:0] C_FSTALL  = {10'b0001000000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0};
  localparam logic [17:0] C_FREADY  = {10'b1001001000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0};
  localparam logic [17:0] C_DECODE  = {10'b0000000000, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0};
  localparam logic [17:0] C_DECILL  = {10'b0000000000, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1};
  localparam logic [17:0] C_MEMADR  = {10'b0000000100, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [17:0] C_MEMRD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_MEMWB   = {10'b0000010010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] C_MEMWR0  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_MEMWR1  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] C_EXEC    = {10'b0000000100, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] C_RWB     = {10'b0000000011, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] C_ADDIWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] C_BRANCH  = {10'b0100000100, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] C_JUMP    = {10'b1000000000, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  // Apply inputs, check state and controls for this cycle, advance one clock.
  task automatic cyc(input string tag, input logic [5:0] op, input logic mr,
                     input logic rst, input logic [3:0] es, input logic [17:0] ec);
    Op = op; mem_ready = mr; reset = rst;
    #1;
    n_chk++;
    assert (state === es) else begin
      n_fail++;
      $error("FAIL %s.state observed=%0d expected=%0d", tag, state, es);
    end
    n_chk++;
    assert (ctl === ec) else begin
      n_fail++;
      $error("FAIL %s.ctl observed=%b expected=%b", tag, ctl, ec);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; Op = RT; mem_ready = 1'b1;
    // Reset with mem_ready high: IRWrite/PCWrite must stay low.
    cyc("rst0", RT, 1'b1, 1'b1, 4'd0, C_ZERO);
    cyc("rst1", RT, 1'b1, 1'b1, 4'd0, C_ZERO);
    cyc("post_rst", RT, 1'b0, 1'b0, 4'd0, C_FSTALL);

    // lw, mem_ready tied high: 0,1,2,3,4
    cyc("lw.F",  LW, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("lw.D",  LW, 1'b1, 1'b0, 4'd1, C_DECODE);
    cyc("lw.MA", LW, 1'b1, 1'b0, 4'd2, C_MEMADR);
    cyc("lw.MR", LW, 1'b1, 1'b0, 4'd3, C_MEMRD);
    cyc("lw.WB", LW, 1'b1, 1'b0, 4'd4, C_MEMWB);

    // sw with three wait cycles in MEMWR
    cyc("sw.F",   SW, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("sw.D",   SW, 1'b1, 1'b0, 4'd1, C_DECODE);
    cyc("sw.MA",  SW, 1'b1, 1'b0, 4'd2, C_MEMADR);
    cyc("sw.W0",  SW, 1'b0, 1'b0, 4'd5, C_MEMWR0);
    cyc("sw.W1",  SW, 1'b0, 1'b0, 4'd5, C_MEMWR0);
    cyc("sw.W2",  SW, 1'b0, 1'b0, 4'd5, C_MEMWR0);
    cyc("sw.W3",  SW, 1'b1, 1'b0, 4'd5, C_MEMWR1);

    // R-type
    cyc("rt.F",  RT, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("rt.D",  RT, 1'b1, 1'b0, 4'd1, C_DECODE);
    cyc("rt.EX", RT, 1'b1, 1'b0, 4'd6, C_EXEC);
    cyc("rt.WB", RT, 1'b1, 1'b0, 4'd7, C_RWB);

    // beq
    cyc("beq.F", BEQ, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("beq.D", BEQ, 1'b1, 1'b0, 4'd1, C_DECODE);
    cyc("beq.B", BEQ, 1'b1, 1'b0, 4'd8, C_BRANCH);

    // j
    cyc("j.F", JMP, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("j.D", JMP, 1'b1, 1'b0, 4'd1, C_DECODE);
    cyc("j.J", JMP, 1'b1, 1'b0, 4'd9, C_JUMP);

    // illegal opcode
    cyc("ill.F", BAD, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("ill.D", BAD, 1'b1, 1'b0, 4'd1, C_DECILL);

    // addi
    cyc("addi.F",  ADDI, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("addi.D",  ADDI, 1'b1, 1'b0, 4'd1, C_DECODE);
    cyc("addi.EX", ADDI, 1'b1, 1'b0, 4'd10, C_MEMADR);
    cyc("addi.WB", ADDI, 1'b1, 1'b0, 4'd11, C_ADDIWB);

    // fetch stall: two wait cycles, single IRWrite/PCWrite pulse
    cyc("fs.S0", RT, 1'b0, 1'b0, 4'd0, C_FSTALL);
    cyc("fs.S1", RT, 1'b0, 1'b0, 4'd0, C_FSTALL);
    cyc("fs.R",  RT, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("fs.D",  RT, 1'b1, 1'b0, 4'd1, C_DECODE);
    cyc("fs.EX", RT, 1'b1, 1'b0, 4'd6, C_EXEC);
    cyc("fs.WB", RT, 1'b1, 1'b0, 4'd7, C_RWB);

    // reset during a MEMRD wait: instruction abandoned, no MEMWB
    cyc("rr.F",   LW, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("rr.D",   LW, 1'b1, 1'b0, 4'd1, C_DECODE);
    cyc("rr.MA",  LW, 1'b1, 1'b0, 4'd2, C_MEMADR);
    cyc("rr.W0",  LW, 1'b0, 1'b0, 4'd3, C_MEMRD);
    cyc("rr.RST", LW, 1'b1, 1'b1, 4'd0, C_ZERO);
    cyc("rr.F2",  LW, 1'b1, 1'b0, 4'd0, C_FREADY);
    cyc("rr.D2",  LW, 1'b1, 1'b0, 4'd1, C_DECODE);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
